// File: rtl/clk_rst_seq_if.sv
// Sequencer-facing signal bundle: lock input, software request, domain resets and status.
// Latency: none, wires only.
// Backpressure: none; level signals.
interface clk_rst_seq_if #(
   parameter int NUM_STAGES = 3
);
   logic                  pll_locked;
   logic                  sw_rst_req;
   logic [NUM_STAGES-1:0] rst_n_out;
   logic                  ready;
   logic [7:0]            lock_lost_cnt;
   logic [2:0]            seq_state;

   // Sequencer side: consumes lock/request, drives resets and status.
   modport master (
      input  pll_locked,
      input  sw_rst_req,
      output rst_n_out,
      output ready,
      output lock_lost_cnt,
      output seq_state
   );

   // Consumer side: PLL/software drive the inputs, reset domains observe the outputs.
   modport slave (
      output pll_locked,
      output sw_rst_req,
      input  rst_n_out,
      input  ready,
      input  lock_lost_cnt,
      input  seq_state
   );
endinterface

// File: rtl/clk_rst_seq.sv
// Reset sequencer: waits for stable PLL lock, then releases reset domains in index order.
// Latency: lock edge -> decision 2 cycles; stage 0 released STABLE_CYCLES after STABLE entry.
// Backpressure: none; lock loss or software request drops every domain on the next edge.
module clk_rst_seq #(
   parameter int NUM_STAGES    = 3,
   parameter int STABLE_CYCLES = 1024,
   parameter int STAGE_GAP     = 16,
   parameter int HOLD_CYCLES   = 8,
   parameter int CNT_W         = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   clk_rst_seq_if.master bus
);

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
   // Index of the stage whose gap expiry releases the final stage.
   localparam logic [2:0]       PEN_STAGE   = 3'(NUM_STAGES - 2);

   state_t                state_q, state_d;
   logic                  sync1_q, lock_s;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            stage_q, stage_d;
   logic [NUM_STAGES-1:0] rst_q, rst_d;
   logic                  ready_q, ready_d;
   logic [7:0]            lost_q, lost_d;
   logic                  loss, abort;

   // Lock loss only matters once a domain may have been released; STABLE just restarts.
   assign loss  = !lock_s && ((state_q == RELEASE) || (state_q == RUN));
   // Software request is ignored in HOLD so the hold period is never stretched.
   assign abort = (state_q != HOLD) && (bus.sw_rst_req || loss);

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync1_q <= bus.pll_locked;
         lock_s  <= sync1_q;
      end
   end

   // State and registered outputs, so no output can glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         stage_q <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
         lost_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         lost_q  <= lost_d;
      end
   end

   // Next-state decision; abort (lock loss or software request) overrides everything.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = HOLD;
      end else begin
         case (state_q)
            HOLD:      if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: if (lock_s) state_d = STABLE;
            STABLE: begin
               if (!lock_s)
                  state_d = WAIT_LOCK;
               else if (cnt_q == STABLE_LAST)
                  state_d = (NUM_STAGES == 1) ? RUN : RELEASE;
            end
            RELEASE:   if ((cnt_q == GAP_LAST) && (stage_q == PEN_STAGE)) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = HOLD;
         endcase
      end
   end

   // Next values of counter, stage index and outputs; releases shift a 1 in by index.
   always_comb begin
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      lost_d  = lost_q;
      if (abort) begin
         cnt_d   = '0;
         stage_d = '0;
         rst_d   = '0;
         ready_d = 1'b0;
         if (loss && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;
      end else begin
         case (state_q)
            HOLD:      cnt_d = (cnt_q == HOLD_LAST) ? '0 : cnt_q + CNT_W'(1);
            WAIT_LOCK: cnt_d = '0;
            STABLE: begin
               if (!lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  cnt_d   = '0;
                  stage_d = '0;
                  rst_d   = NUM_STAGES'(1);
                  ready_d = (NUM_STAGES == 1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  stage_d = stage_q + 3'd1;
                  rst_d   = rst_q | (NUM_STAGES'(1) << (stage_q + 3'd1));
                  ready_d = (stage_q == PEN_STAGE);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               rst_d   = '1;
               ready_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.rst_n_out     = rst_q;
   assign bus.ready         = ready_q;
   assign bus.lock_lost_cnt = lost_q;
   assign bus.seq_state     = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: vector table for the main sequence plus corner sequences.
// Latency: expectations count edges from STABLE entry (STABLE_CYCLES) and between stages (STAGE_GAP).
// Backpressure: not applicable.
module tb_clk_rst_seq;

   localparam int N  = 3;
   localparam int SC = 64;
   localparam int SG = 16;
   localparam int HC = 8;

   logic clk;
   logic reset_n;

   clk_rst_seq_if #(.NUM_STAGES(N)) bus ();

   clk_rst_seq #(
      .NUM_STAGES   (N),
      .STABLE_CYCLES(SC),
      .STAGE_GAP    (SG),
      .HOLD_CYCLES  (HC),
      .CNT_W        (16)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      logic       lock;
      logic       sw;
      int         n;
      logic [2:0] rst;
      logic       rdy;
      logic [7:0] cnt;
      logic [2:0] st;
   } vec_t;

   vec_t tbl[36];
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic sv(input int i, input logic l, input logic s, input int n,
                     input logic [2:0] r, input logic rd, input logic [7:0] c,
                     input logic [2:0] st);
      tbl[i].lock = l;
      tbl[i].sw   = s;
      tbl[i].n    = n;
      tbl[i].rst  = r;
      tbl[i].rdy  = rd;
      tbl[i].cnt  = c;
      tbl[i].st   = st;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.pll_locked = tbl[i].lock;
         bus.sw_rst_req = tbl[i].sw;
         repeat (tbl[i].n) tick();
         chk($sformatf("v%0d.rst_n_out", i), 32'(bus.rst_n_out), 32'(tbl[i].rst));
         chk($sformatf("v%0d.ready", i), 32'(bus.ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d.lock_lost_cnt", i), 32'(bus.lock_lost_cnt), 32'(tbl[i].cnt));
         chk($sformatf("v%0d.seq_state", i), 32'(bus.seq_state), 32'(tbl[i].st));
      end
   endtask

   task automatic wait_state(input logic [2:0] a, input logic [2:0] b, input int budget,
                             input string name);
      int k = 0;
      while (!((bus.seq_state == a) || (bus.seq_state == b)) && (k < budget)) begin
         tick();
         k++;
      end
      if ((bus.seq_state != a) && (bus.seq_state != b)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: timeout, state %0d, want %0d or %0d", name, bus.seq_state, a, b);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".rst_n_out"}, 32'(bus.rst_n_out), 32'd0);
      chk({tag, ".ready"}, 32'(bus.ready), 32'd0);
      chk({tag, ".lock_lost_cnt"}, 32'(bus.lock_lost_cnt), 32'd0);
      chk({tag, ".seq_state"}, 32'(bus.seq_state), 32'd0);
   endtask

   initial begin
      int exp_lost;

      // Lock high from time 0: HOLD (8), WAIT_LOCK (1), STABLE (64), then stages every 16.
      sv( 0, 1, 0,  1, 3'b000, 0, 0, 0);
      sv( 1, 1, 0,  7, 3'b000, 0, 0, 1);
      sv( 2, 1, 0,  1, 3'b000, 0, 0, 2);
      sv( 3, 1, 0, 63, 3'b000, 0, 0, 2);
      sv( 4, 1, 0,  1, 3'b001, 0, 0, 3);
      sv( 5, 1, 0, 15, 3'b001, 0, 0, 3);
      sv( 6, 1, 0,  1, 3'b011, 0, 0, 3);
      sv( 7, 1, 0, 15, 3'b011, 0, 0, 3);
      sv( 8, 1, 0,  1, 3'b111, 1, 0, 4);
      sv( 9, 1, 0, 20, 3'b111, 1, 0, 4);
      // Lock drop in RUN: 2 sync edges, then everything falls on the next edge.
      sv(10, 0, 0,  2, 3'b111, 1, 0, 4);
      sv(11, 0, 0,  1, 3'b000, 0, 1, 0);
      // Relock during HOLD; full sequence repeats.
      sv(12, 1, 0,  7, 3'b000, 0, 1, 0);
      sv(13, 1, 0,  1, 3'b000, 0, 1, 1);
      sv(14, 1, 0,  1, 3'b000, 0, 1, 2);
      sv(15, 1, 0, 64, 3'b001, 0, 1, 3);
      sv(16, 1, 0, 32, 3'b111, 1, 1, 4);
      // Software pulse in RUN, second pulse in HOLD must not extend the hold.
      sv(17, 1, 1,  1, 3'b000, 0, 1, 0);
      sv(18, 1, 0,  3, 3'b000, 0, 1, 0);
      sv(19, 1, 1,  1, 3'b000, 0, 1, 0);
      sv(20, 1, 0,  3, 3'b000, 0, 1, 0);
      sv(21, 1, 0,  1, 3'b000, 0, 1, 1);
      sv(22, 1, 0,  1, 3'b000, 0, 1, 2);
      sv(23, 1, 0, 64, 3'b001, 0, 1, 3);
      // Lock loss and software request together in RELEASE: counted once.
      sv(24, 0, 0,  2, 3'b001, 0, 1, 3);
      sv(25, 0, 1,  1, 3'b000, 0, 2, 0);
      sv(26, 0, 0, 20, 3'b000, 0, 2, 1);
      // One-cycle lock glitch at STABLE count 30 restarts the stability count.
      sv(27, 1, 0,  3, 3'b000, 0, 2, 2);
      sv(28, 1, 0, 30, 3'b000, 0, 2, 2);
      sv(29, 0, 0,  1, 3'b000, 0, 2, 2);
      sv(30, 1, 0,  1, 3'b000, 0, 2, 2);
      sv(31, 1, 0,  1, 3'b000, 0, 2, 1);
      sv(32, 1, 0,  1, 3'b000, 0, 2, 2);
      sv(33, 1, 0, 63, 3'b000, 0, 2, 2);
      sv(34, 1, 0,  1, 3'b001, 0, 2, 3);
      sv(35, 1, 0, 32, 3'b111, 1, 2, 4);

      reset_n        = 1'b0;
      bus.pll_locked = 1'b1;
      bus.sw_rst_req = 1'b0;
      repeat (3) tick();
      chk_reset("por");
      reset_n = 1'b1;

      run_vecs(0, 35);

      // Repeated lock losses in RELEASE/RUN; count saturates at 255.
      exp_lost = 2;
      for (int i = 0; i < 300; i++) begin
         wait_state(3'd3, 3'd4, 200, "sat.reach_release");
         bus.pll_locked = 1'b0;
         wait_state(3'd0, 3'd0, 10, "sat.reach_hold");
         bus.pll_locked = 1'b1;
         exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
         chk($sformatf("sat%0d.lock_lost_cnt", i), 32'(bus.lock_lost_cnt), 32'(exp_lost));
      end
      chk("sat.final", 32'(bus.lock_lost_cnt), 32'd255);

      // Asynchronous reset mid-RELEASE drops outputs with no clock edge.
      wait_state(3'd3, 3'd3, 200, "arst.reach_release");
      repeat (5) tick();
      chk("arst.pre_rst_n_out", 32'(bus.rst_n_out), 32'b001);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset("arst");
      repeat (3) tick();
      reset_n = 1'b1;
      run_vecs(0, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
